// File: rtl/mmio_game_pkg.sv
// Shared constants, command field layout and flash FSM state type for the game I/O peripheral.
// No logic: consumed by mmio_game_io and its interface.
package mmio_game_pkg;

  localparam int RAND_ADDR_DEF   = 5;
  localparam int LED_ADDR_DEF    = 6;
  localparam int STATUS_ADDR_DEF = 7;

  localparam int ON_BIT   = 0;
  localparam int CH_LSB   = 1;
  localparam int CH_MSB   = 4;
  localparam int TICK_LSB = 16;
  localparam int TICK_MSB = 31;

  localparam int ST_BUSY_BIT = 8;
  localparam int ST_OVF_BIT  = 9;

  typedef enum logic [1:0] {IDLE, ON, GAP} flash_state_t;

  // Maximal-length Fibonacci tap masks (bit n-1 set for tap n); widths outside the table fall back to 16.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_D008;
    endcase
  endfunction

endpackage

// File: rtl/mmio_game_if.sv
// Processor data-port / data-RAM bus seen by the game I/O peripheral.
// Pure wiring: master is the processor side, slave is the peripheral.
interface mmio_game_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              wren;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] q_dmem;

  modport master (output wren, output address_dmem, output data, output ram_q, input q_dmem);
  modport slave  (input wren, input address_dmem, input data, input ram_q, output q_dmem);
endinterface

// File: rtl/mmio_game_io_cmd_fifo.sv
// Synchronous FIFO with first-word fall-through head, flush beats push/pop.
// Latency 1 edge push-to-visible; push when full is refused unless popping in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_en, rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];
  assign rd_en = pop & ~empty & ~flush;
  assign wr_en = push & (~full | rd_en) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_game_io.sv
// Game I/O peripheral: LFSR/status read mux over RAM, queued LED flash player with timed on/gap phases.
// Reads are combinational; a queued flash lights one edge after its push, a full queue drops and flags overflow.
module mmio_game_io
  import mmio_game_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 32,
  parameter int          NUM_LEDS    = 4,
  parameter int          LFSR_W      = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1,
  parameter int          RAND_ADDR   = RAND_ADDR_DEF,
  parameter int          LED_ADDR    = LED_ADDR_DEF,
  parameter int          STATUS_ADDR = STATUS_ADDR_DEF,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TICK_CYCLES = 25_000_000,
  parameter int          DEF_TICKS   = 8,
  parameter int          GAP_TICKS   = 4
) (
  input  logic                clock,
  input  logic                reset,
  mmio_game_if.slave          bus,
  output logic [NUM_LEDS-1:0] led,
  output logic                busy
);
  localparam int          CH_W  = CH_MSB - CH_LSB + 1;
  localparam int          TK_W  = TICK_MSB - TICK_LSB + 1;
  localparam int          ENT_W = CH_W + TK_W;
  localparam int          CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [31:0] TAPS  = lfsr_taps(LFSR_W);

  logic [LFSR_W-1:0] lfsr;
  logic              ovf;
  flash_state_t      state;
  logic [CYC_W-1:0]  cyc;
  logic [TK_W-1:0]   tick, tgt, last;
  logic [CH_W-1:0]   cmd_ch, head_ch;
  logic [TK_W-1:0]   cmd_ticks, head_ticks;
  logic              hit_led, hit_status, hit_rand, cmd_wr, abort, cmd_req, push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] rd_dat, status;
  logic              unused_data;

  assign hit_led    = (bus.address_dmem == ADDR_W'(LED_ADDR));
  assign hit_status = (bus.address_dmem == ADDR_W'(STATUS_ADDR));
  assign hit_rand   = (bus.address_dmem == ADDR_W'(RAND_ADDR));
  assign cmd_ch     = bus.data[CH_MSB:CH_LSB];
  assign cmd_ticks  = bus.data[TICK_MSB:TICK_LSB];
  assign cmd_wr     = bus.wren & hit_led;
  assign abort      = cmd_wr & ~bus.data[ON_BIT];
  assign cmd_req    = cmd_wr & bus.data[ON_BIT] & ({1'b0, cmd_ch} < (CH_W+1)'(NUM_LEDS));
  assign pop        = (state == IDLE) & ~fifo_empty & ~abort;
  assign push       = cmd_req & (~fifo_full | pop);
  assign busy       = (state != IDLE) | ~fifo_empty;
  assign unused_data = ^bus.data[TICK_LSB-1:CH_MSB+1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED[LFSR_W-1:0];
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS[LFSR_W-1:0])};
  end

  // A dropped command in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              ovf <= 1'b0;
    else if (cmd_req & fifo_full & ~pop)    ovf <= 1'b1;
    else if (bus.wren & hit_status)         ovf <= 1'b0;
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   ({cmd_ch, cmd_ticks}),
    .dout  ({head_ch, head_ticks}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last = (state == ON) ? tgt - TK_W'(1) : TK_W'(GAP_TICKS - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      led   <= '0;
      cyc   <= '0;
      tick  <= '0;
      tgt   <= '0;
    end else if (abort) begin
      state <= IDLE;
      led   <= '0;
      cyc   <= '0;
      tick  <= '0;
      tgt   <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          led   <= NUM_LEDS'(1) << head_ch;
          tgt   <= (head_ticks == '0) ? TK_W'(DEF_TICKS) : head_ticks;
          cyc   <= '0;
          tick  <= '0;
          state <= ON;
        end
        ON, GAP: begin
          if (cyc == CYC_W'(TICK_CYCLES - 1)) begin
            cyc <= '0;
            if (tick == last) begin
              tick <= '0;
              if (state == ON) begin
                led   <= '0;
                state <= GAP;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick <= tick + TK_W'(1);
            end
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status                = '0;
    status[NUM_LEDS-1:0]  = led;
    status[ST_BUSY_BIT]   = busy;
    status[ST_OVF_BIT]    = ovf;
    rd_dat                = bus.ram_q;
    if (hit_rand)        rd_dat = DATA_W'(lfsr);
    else if (hit_status) rd_dat = status;
  end

  assign bus.q_dmem = rd_dat;
endmodule

// File: tb/tb_mmio_game_io.sv
// Directed bench for mmio_game_io with short tick timing; every check is an immediate assertion.
module tb_mmio_game_io;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led;
  logic       busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] v0;

  mmio_game_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  mmio_game_io #(
    .TICK_CYCLES(2), .DEF_TICKS(2), .GAP_TICKS(1), .FIFO_DEPTH(2), .NUM_LEDS(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .led   (led),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] d);
    bus.wren         = w;
    bus.address_dmem = a;
    bus.data         = d;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

  initial begin
    drive(1'b0, 12'd5, 32'd0);
    bus.ram_q = 32'h1234_5678;
    #12 reset = 1'b0;
    #1;
    chk("rand_reset", bus.q_dmem, 32'h0000_ACE1);
    chk("led_reset", 32'(led), 32'h0);
    chk("busy_reset", 32'(busy), 32'h0);
    drive(1'b0, 12'd7, 32'd0);
    #1 chk("status_reset", bus.q_dmem, 32'h0);
    drive(1'b0, 12'd5, 32'd0);
    tick();
    chk("rand_step1", bus.q_dmem, 32'h0000_59C3);
    tick();
    chk("rand_step2", bus.q_dmem, 32'h0000_B386);

    // single flash: channel 2, 3 ticks
    drive(1'b1, 12'd6, 32'h0003_0005);
    tick();
    drive(1'b0, 12'd7, 32'd0);
    #1;
    chk("flash_pushed_led", 32'(led), 32'h0);
    chk("flash_pushed_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flash_on", 32'(led), 32'h4);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("flash_gap_led", 32'(led), 32'h0);
      chk("flash_gap_busy", 32'(busy), 32'h1);
    end
    tick();
    chk("flash_done_busy", 32'(busy), 32'h0);

    // four back-to-back commands into a two-entry queue
    drive(1'b1, 12'd6, 32'h1); tick();
    drive(1'b1, 12'd6, 32'h3); tick();
    chk("queue_first_on", 32'(led), 32'h1);
    drive(1'b1, 12'd6, 32'h5); tick();
    drive(1'b1, 12'd6, 32'h7); tick();
    drive(1'b0, 12'd7, 32'd0);
    #1 chk("ovf_status", bus.q_dmem, 32'h0000_0301);
    for (int k = 5; k <= 22; k++) begin
      tick();
      chk("queue_led", 32'(led), ((k - 2) % 7 < 4) ? (32'h1 << ((k - 2) / 7)) : 32'h0);
      chk("queue_busy", 32'(busy), (k < 22) ? 32'h1 : 32'h0);
    end

    // abort during ON with a command still queued
    drive(1'b1, 12'd6, 32'h3); tick();
    drive(1'b1, 12'd6, 32'h7); tick();
    drive(1'b0, 12'd7, 32'd0);
    #1 chk("abort_pre_led", 32'(led), 32'h2);
    drive(1'b1, 12'd6, 32'h0); tick();
    drive(1'b0, 12'd7, 32'd0);
    #1;
    chk("abort_led", 32'(led), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_status", bus.q_dmem, 32'h0000_0200);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_quiet", {31'd0, busy} | 32'(led), 32'h0);
    end

    // out-of-range channel is ignored
    drive(1'b1, 12'd6, 32'h0000_000B); tick();
    drive(1'b0, 12'd7, 32'd0);
    #1 chk("badch_status", bus.q_dmem, 32'h0000_0200);
    tick();
    chk("badch_led", 32'(led), 32'h0);

    // clear overflow, then read pass-through
    drive(1'b1, 12'd7, 32'd0); tick();
    drive(1'b0, 12'd7, 32'd0);
    #1 chk("ovf_clear", bus.q_dmem, 32'h0);
    bus.ram_q = 32'hDEAD_BEEF;
    drive(1'b0, 12'd9, 32'd0);
    #1 chk("pass_addr9", bus.q_dmem, 32'hDEAD_BEEF);
    drive(1'b0, 12'd6, 32'd0);
    #1 chk("pass_addr6", bus.q_dmem, 32'hDEAD_BEEF);
    drive(1'b0, 12'h105, 32'd0);
    #1 chk("pass_addr105", bus.q_dmem, 32'hDEAD_BEEF);

    // write to the random address does not disturb the sequence
    drive(1'b0, 12'd5, 32'd0);
    #1 v0 = bus.q_dmem;
    drive(1'b1, 12'd5, 32'hFFFF_FFFF); tick();
    drive(1'b0, 12'd5, 32'd0);
    #1 chk("rand_write_ignored", bus.q_dmem, {16'h0, lfsr_next(v0[15:0])});

    // asynchronous reset in the middle of a flash
    drive(1'b1, 12'd6, 32'h1); tick();
    drive(1'b0, 12'd7, 32'd0); tick();
    #1 chk("rst_pre_led", 32'(led), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_status", bus.q_dmem, 32'h0);
    drive(1'b0, 12'd5, 32'd0);
    #1 chk("rst_rand", bus.q_dmem, 32'h0000_ACE1);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", {31'd0, busy} | 32'(led), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
